// File: rtl/vga_menu_pkg.sv
// vga_menu_pkg: default 640x480@60 timing, the click/hover
// hit bundle and the signed cursor helpers.
package vga_menu_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CW       = 10;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } hit_t;

  function automatic int tot(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int sext9(input logic [8:0] d);
    return int'($signed(d));
  endfunction

  function automatic int clamp(
    input int v,
    input int lo,
    input int hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vga_menu_ctrl_timing.sv
// vga_timing_gen: pixel-enable divider, h/v counters and the
// registered sync/active/position outputs.
// Ports: in_clk, reset (async, active-low) -> pix_en, hsync,
// vsync, active, pix_x, pix_y, frame_start, vblank_start.
module vga_timing_gen
  import vga_menu_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CW       = DEF_CW
) (
  input  logic          in_clk,
  input  logic          reset,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int H_TOT = tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS0   = H_ACTIVE + H_FP;
  localparam int VS0   = V_ACTIVE + V_FP;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          in_hs;
  logic          in_vs;

  always_comb begin
    div_nxt = div_cnt + 1'b1;
    if (div_cnt == DW'(CLK_DIV - 1)) div_nxt = '0;
    h_wrap = (h_cnt == CW'(H_TOT - 1));
    v_wrap = (v_cnt == CW'(V_TOT - 1));
    in_hs  = (h_cnt >= CW'(HS0)) &&
             (h_cnt <  CW'(HS0 + H_SYNC));
    in_vs  = (v_cnt >= CW'(VS0)) &&
             (v_cnt <  CW'(VS0 + V_SYNC));
  end

  // Counters move to (0, V_ACTIVE) on this edge.
  assign vblank_start = pix_en && h_wrap &&
                        (v_cnt == CW'(V_ACTIVE - 1));

  // pix_en is registered so it stays low during reset,
  // even when CLK_DIV is 1.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      active      <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      pix_en      <= (div_nxt == DW'(CLK_DIV - 1));
      frame_start <= 1'b0;
      if (pix_en) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        pix_x  <= h_cnt;
        pix_y  <= v_cnt;
        active <= (h_cnt < CW'(H_ACTIVE)) &&
                  (v_cnt < CW'(V_ACTIVE));
        hsync  <= in_hs ? SYNC_POL : ~SYNC_POL;
        vsync  <= in_vs ? SYNC_POL : ~SYNC_POL;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

endmodule

// File: rtl/vga_menu_ctrl.sv
// vga_menu_ctrl: VGA timing, PS/2 cursor with per-frame
// commit, cursor overlay flag and prioritised click regions.
// Ports: in_clk, reset, mv_* packet in, region_* rectangles in;
// sync/pixel outputs, cursor_*, hover_* and click_* out.
module vga_menu_ctrl
  import vga_menu_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_POL    = 1'b0,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int NUM_REGIONS = 4,
  parameter int CUR_SIZE    = 16,
  parameter int CW          = DEF_CW
) (
  input  logic                      in_clk,
  input  logic                      reset,
  input  logic                      mv_valid,
  input  logic [8:0]                mv_dx,
  input  logic [8:0]                mv_dy,
  input  logic [2:0]                mv_btn,
  input  logic [NUM_REGIONS-1:0]    region_en,
  input  logic [NUM_REGIONS*CW-1:0] region_x0,
  input  logic [NUM_REGIONS*CW-1:0] region_x1,
  input  logic [NUM_REGIONS*CW-1:0] region_y0,
  input  logic [NUM_REGIONS*CW-1:0] region_y1,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      active,
  output logic [CW-1:0]             pix_x,
  output logic [CW-1:0]             pix_y,
  output logic                      pix_en,
  output logic                      frame_start,
  output logic [CW-1:0]             cursor_x,
  output logic [CW-1:0]             cursor_y,
  output logic                      cursor_on,
  output logic                      click_valid,
  output logic [3:0]                click_idx,
  output logic                      click_miss,
  output logic [3:0]                hover_idx,
  output logic                      hover_valid
);

  localparam int W = CW + 2;
  localparam logic [CW-1:0] CX0 = CW'(H_ACTIVE / 2);
  localparam logic [CW-1:0] CY0 = CW'(V_ACTIVE / 2);

  logic                vblank_start;
  logic [CW-1:0]       pend_x;
  logic [CW-1:0]       pend_y;
  logic signed [W-1:0] sum_x;
  logic signed [W-1:0] sum_y;
  logic [CW-1:0]       nxt_x;
  logic [CW-1:0]       nxt_y;
  logic                prev_left;
  logic                press;
  logic [CW:0]         cur_x_end;
  logic [CW:0]         cur_y_end;
  hit_t                hit;
  logic                unused_btn;

  assign unused_btn = ^mv_btn[2:1];

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .CLK_DIV  (CLK_DIV),
    .CW       (CW)
  ) u_timing (
    .in_clk       (in_clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .hsync        (hsync),
    .vsync        (vsync),
    .active       (active),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .frame_start  (frame_start),
    .vblank_start (vblank_start)
  );

  // Two guard bits keep the sum from wrapping before clamping.
  always_comb begin
    sum_x = $signed({2'b00, pend_x}) + W'(sext9(mv_dx));
    sum_y = $signed({2'b00, pend_y}) - W'(sext9(mv_dy));
    nxt_x = CW'(clamp(int'(sum_x), 0, H_ACTIVE - 1));
    nxt_y = CW'(clamp(int'(sum_y), 0, V_ACTIVE - 1));
  end

  // Extra bit so the far edge cannot overflow near the border.
  always_comb begin
    cur_x_end = {1'b0, cursor_x} + (CW+1)'(CUR_SIZE - 1);
    cur_y_end = {1'b0, cursor_y} + (CW+1)'(CUR_SIZE - 1);
    cursor_on = active &&
                (pix_x >= cursor_x) &&
                ({1'b0, pix_x} <= cur_x_end) &&
                (pix_y >= cursor_y) &&
                ({1'b0, pix_y} <= cur_y_end);
  end

  // Walk downwards so the lowest matching index wins.
  always_comb begin
    hit = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (region_en[i] &&
          cursor_x >= region_x0[i*CW +: CW] &&
          cursor_x <= region_x1[i*CW +: CW] &&
          cursor_y >= region_y0[i*CW +: CW] &&
          cursor_y <= region_y1[i*CW +: CW]) begin
        hit.valid = 1'b1;
        hit.idx   = 4'(i);
      end
    end
  end

  assign press = mv_valid && mv_btn[0] && !prev_left;

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      pend_x      <= CX0;
      pend_y      <= CY0;
      cursor_x    <= CX0;
      cursor_y    <= CY0;
      prev_left   <= 1'b0;
      hover_valid <= 1'b0;
      hover_idx   <= '0;
      click_valid <= 1'b0;
      click_miss  <= 1'b0;
      click_idx   <= '0;
    end else begin
      hover_valid <= hit.valid;
      hover_idx   <= hit.idx;
      click_valid <= press && hit.valid;
      click_miss  <= press && !hit.valid;
      if (press && hit.valid) click_idx <= hit.idx;
      if (vblank_start) begin
        cursor_x <= pend_x;
        cursor_y <= pend_y;
      end
      if (mv_valid) begin
        pend_x    <= nxt_x;
        pend_y    <= nxt_y;
        prev_left <= mv_btn[0];
      end
    end
  end

endmodule

// File: tb/tb_vga_menu_ctrl.sv
// tb_vga_menu_ctrl: directed and random packets checked every
// cycle against an arithmetic model of timing, cursor and clicks.
module tb_vga_menu_ctrl;

  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HB  = 6;
  localparam int VA  = 24;
  localparam int VFP = 2;
  localparam int VS  = 3;
  localparam int VB  = 3;
  localparam bit POL = 1'b0;
  localparam int D   = 2;
  localparam int NR  = 4;
  localparam int CS  = 4;
  localparam int CW  = 10;
  localparam int HT  = HA + HFP + HS + HB;
  localparam int VT  = VA + VFP + VS + VB;
  localparam int FT  = HT * VT;

  logic             in_clk;
  logic             reset;
  logic             mv_valid;
  logic [8:0]       mv_dx;
  logic [8:0]       mv_dy;
  logic [2:0]       mv_btn;
  logic [NR-1:0]    ren;
  logic [NR*CW-1:0] region_x0;
  logic [NR*CW-1:0] region_x1;
  logic [NR*CW-1:0] region_y0;
  logic [NR*CW-1:0] region_y1;
  logic             hsync;
  logic             vsync;
  logic             active;
  logic [CW-1:0]    pix_x;
  logic [CW-1:0]    pix_y;
  logic             pix_en;
  logic             frame_start;
  logic [CW-1:0]    cursor_x;
  logic [CW-1:0]    cursor_y;
  logic             cursor_on;
  logic             click_valid;
  logic [3:0]       click_idx;
  logic             click_miss;
  logic [3:0]       hover_idx;
  logic             hover_valid;

  int rx0[NR];
  int rx1[NR];
  int ry0[NR];
  int ry1[NR];

  for (genvar g = 0; g < NR; g++) begin : g_reg
    assign region_x0[g*CW +: CW] = CW'(rx0[g]);
    assign region_x1[g*CW +: CW] = CW'(rx1[g]);
    assign region_y0[g*CW +: CW] = CW'(ry0[g]);
    assign region_y1[g*CW +: CW] = CW'(ry1[g]);
  end

  vga_menu_ctrl #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL), .CLK_DIV (D), .NUM_REGIONS (NR),
    .CUR_SIZE (CS), .CW (CW)
  ) dut (
    .in_clk      (in_clk),
    .reset       (reset),
    .mv_valid    (mv_valid),
    .mv_dx       (mv_dx),
    .mv_dy       (mv_dy),
    .mv_btn      (mv_btn),
    .region_en   (ren),
    .region_x0   (region_x0),
    .region_x1   (region_x1),
    .region_y0   (region_y0),
    .region_y1   (region_y1),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_en      (pix_en),
    .frame_start (frame_start),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .cursor_on   (cursor_on),
    .click_valid (click_valid),
    .click_idx   (click_idx),
    .click_miss  (click_miss),
    .hover_idx   (hover_idx),
    .hover_valid (hover_valid)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference state: cycles since reset release, cursors,
  // previous left button and the expected registered outputs.
  int c;
  int cpx, cpy, ppx, ppy;
  bit prev_l;
  bit committed;
  bit exp_cv, exp_cm, exp_hv;
  int exp_ci, exp_hi;
  int t, dx, dy;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [8:0] d);
    int v;
    v = int'(d);
    if (v >= 256) v = v - 512;
    return v;
  endfunction

  function automatic int clampi(input int v, input int lo,
                                input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int hit(input int x, input int y);
    for (int i = 0; i < NR; i++)
      if (ren[i] && x >= rx0[i] && x <= rx1[i] &&
          y >= ry0[i] && y <= ry1[i]) return i;
    return -1;
  endfunction

  task automatic mdl_reset();
    c = 0;
    cpx = HA / 2; cpy = VA / 2;
    ppx = HA / 2; ppy = VA / 2;
    prev_l = 0;
    exp_cv = 0; exp_cm = 0; exp_ci = 0;
    exp_hv = 0; exp_hi = 0;
  endtask

  task automatic check_all();
    int k, p, x, y;
    bit e_act, e_hs, e_vs, e_fs, e_pe, e_on;
    k = c / D;
    e_pe = (c >= 1) && (c % D == D - 1);
    if (k == 0) begin
      x = 0; y = 0; e_act = 0; e_fs = 0;
      e_hs = !POL; e_vs = !POL;
    end else begin
      p = (k - 1) % FT;
      x = p % HT;
      y = p / HT;
      e_act = (x < HA) && (y < VA);
      e_hs = (x >= HA + HFP && x < HA + HFP + HS) ? POL : !POL;
      e_vs = (y >= VA + VFP && y < VA + VFP + VS) ? POL : !POL;
      e_fs = (c % D == 0) && (p == 0);
    end
    e_on = e_act && x >= cpx && x <= cpx + CS - 1 &&
           y >= cpy && y <= cpy + CS - 1;
    chk("pix_en", pix_en, e_pe);
    chk("pix_x", pix_x, x);
    chk("pix_y", pix_y, y);
    chk("active", active, e_act);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("frame_start", frame_start, e_fs);
    chk("cursor_x", cursor_x, cpx);
    chk("cursor_y", cursor_y, cpy);
    chk("cursor_on", cursor_on, e_on);
    chk("hover_valid", hover_valid, exp_hv);
    chk("hover_idx", hover_idx, exp_hi);
    chk("click_valid", click_valid, exp_cv);
    chk("click_miss", click_miss, exp_cm);
    if (exp_cv) chk("click_idx", click_idx, exp_ci);
  endtask

  task automatic step();
    int h;
    @(posedge in_clk);
    if (!reset) mdl_reset();
    else begin
      h = hit(cpx, cpy);
      exp_cv = 0; exp_cm = 0;
      if (mv_valid && mv_btn[0] && !prev_l) begin
        if (h >= 0) begin exp_cv = 1; exp_ci = h; end
        else exp_cm = 1;
      end
      if (mv_valid) prev_l = mv_btn[0];
      exp_hv = (h >= 0);
      exp_hi = (h >= 0) ? h : 0;
      c++;
      if (c % D == 0 && (c / D) % FT == VA * HT) begin
        cpx = ppx; cpy = ppy; committed = 1;
      end
      if (mv_valid) begin
        ppx = clampi(ppx + sx(mv_dx), 0, HA - 1);
        ppy = clampi(ppy - sx(mv_dy), 0, VA - 1);
      end
    end
    #1;
    check_all();
    if (click_valid || click_miss) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic packet(input int pdx, input int pdy,
                        input logic [2:0] btn);
    mv_valid = 1'b1;
    mv_dx = 9'(pdx);
    mv_dy = 9'(pdy);
    mv_btn = btn;
    step();
    mv_valid = 1'b0;
    mv_dx = '0; mv_dy = '0; mv_btn = '0;
  endtask

  task automatic wait_commit();
    committed = 0;
    for (int i = 0; i < 2 * FT * D && !committed; i++) step();
    chk("commit_seen", 32'(committed), 1);
  endtask

  task automatic set_reg(input int i, input int x0, input int x1,
                         input int y0, input int y1, input bit en);
    rx0[i] = x0; rx1[i] = x1; ry0[i] = y0; ry1[i] = y1;
    ren[i] = en;
  endtask

  initial begin
    reset = 1'b0;
    mv_valid = 1'b0; mv_dx = '0; mv_dy = '0; mv_btn = '0;
    ren = '0;
    mdl_reset();
    idle(3);
    reset = 1'b1;

    // first pixel enable carries frame_start
    idle(D);
    chk("first_frame_start", frame_start, 1);

    // motion is held back until vertical blank
    idle(17);
    packet(5, 3, 3'b000);
    chk("hold_x", cursor_x, HA / 2);
    chk("hold_y", cursor_y, VA / 2);
    wait_commit();
    chk("move_x", cursor_x, HA / 2 + 5);
    chk("move_y", cursor_y, VA / 2 - 3);

    // clamping at both edges
    packet(2 - (HA / 2 + 5), 0, 3'b000);
    wait_commit();
    chk("x_at_2", cursor_x, 2);
    packet(-5, 0, 3'b000);
    wait_commit();
    chk("clamp_x0", cursor_x, 0);
    packet(255, 100, 3'b000);
    packet(255, 0, 3'b000);
    packet(255, -255, 3'b000);
    wait_commit();
    chk("clamp_xmax", cursor_x, HA - 1);
    chk("clamp_ymax", cursor_y, VA - 1);

    // overlapping regions, priority and miss
    set_reg(0, 10, 30, 6, 16, 1'b1);
    set_reg(1, 20, 35, 4, 20, 1'b1);
    packet(25 - (HA - 1), (VA - 1) - 10, 3'b000);
    wait_commit();
    idle(2);
    chk("hover_r0", hover_idx, 0);
    packet(0, 0, 3'b001);
    chk("click_r0", click_valid, 1);
    chk("click_r0_idx", click_idx, 0);
    packet(0, 0, 3'b000);
    ren[0] = 1'b0;
    packet(0, 0, 3'b001);
    chk("click_r1_idx", click_idx, 1);
    packet(0, 0, 3'b000);
    ren[0] = 1'b1;
    set_reg(2, 5, 0, 0, VA - 1, 1'b1);
    packet(-23, 8, 3'b000);
    wait_commit();
    packet(0, 0, 3'b101);
    chk("click_miss", click_miss, 1);

    // a held button clicks once
    packet(0, 0, 3'b000);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      packet(0, 0, 3'b001);
      idle(3);
    end
    chk("held_once", pulses, 1);
    packet(0, 0, 3'b000);
    packet(0, 0, 3'b001);
    chk("repress", pulses, 2);

    // random packets and region programming
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        for (int i = 0; i < NR; i++) begin
          rx0[i] = $urandom_range(0, HA - 1);
          rx1[i] = $urandom_range(0, HA - 1);
          ry0[i] = $urandom_range(0, VA - 1);
          ry1[i] = $urandom_range(0, VA - 1);
          if ($urandom_range(0, 3) != 0 && rx0[i] > rx1[i]) begin
            t = rx0[i]; rx0[i] = rx1[i]; rx1[i] = t;
          end
          if ($urandom_range(0, 3) != 0 && ry0[i] > ry1[i]) begin
            t = ry0[i]; ry0[i] = ry1[i]; ry1[i] = t;
          end
          ren[i] = ($urandom_range(0, 3) != 0);
        end
      end
      if ($urandom_range(0, 7) == 0)
        dx = int'($urandom_range(0, 511)) - 256;
      else
        dx = int'($urandom_range(0, 16)) - 8;
      dy = int'($urandom_range(0, 12)) - 6;
      packet(dx, dy, 3'($urandom_range(0, 7)));
      idle($urandom_range(0, 80));
    end

    // asynchronous reset in the middle of a line
    packet(0, 0, 3'b001);
    idle(2 * HT * D + 37);
    #2;
    reset = 1'b0;
    mdl_reset();
    #1;
    check_all();
    chk("rst_click_idx", click_idx, 0);
    chk("rst_hover_idx", hover_idx, 0);
    packet(7, 7, 3'b001);
    idle(2);
    reset = 1'b1;
    pulses = 0;
    idle(D);
    chk("rst_frame_start", frame_start, 1);
    chk("rst_no_pulse", pulses, 0);
    packet(0, 0, 3'b001);
    chk("rst_prev_cleared", pulses, 1);
    wait_commit();
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_menu_ctrl.md
Name: vga_menu_ctrl

Overview:
Parametrised VGA menu controller, successor to the fixed 640x480 menu display block. It has four parts:
- A generic sync/timing generator with a pixel-enable divider.
- A PS/2-driven cursor accumulator, clamped at the screen edges and committed once per frame so the cursor does not tear.
- A cursor overlay flag.
- Priority hit-testing of NUM_REGIONS runtime-programmable click rectangles.

It sits between the PS/2 mouse receiver and the pixel-colour/menu logic, which consume pix_x/pix_y/active/cursor_on and the click events.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync level while asserted (0 = active-low)
CLK_DIV, 4, in_clk cycles per pixel (>=1)
NUM_REGIONS, 4, number of click rectangles (1..16)
CUR_SIZE, 16, cursor square edge in pixels
CW, 10, coordinate width (must hold H_ACTIVE+H_FP+H_SYNC+H_BP-1)

Ports:
in_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mv_valid  in  1  one-cycle strobe: new PS/2 packet
mv_dx  in  9  two's-complement X delta (+ = right)
mv_dy  in  9  two's-complement Y delta (+ = up)
mv_btn  in  3  buttons from packet [0]=left [1]=right [2]=middle
region_en  in  NUM_REGIONS  per-region enable
region_x0  in  NUM_REGIONS*CW  left bounds, inclusive (region i at [i*CW +: CW])
region_x1  in  NUM_REGIONS*CW  right bounds, inclusive
region_y0  in  NUM_REGIONS*CW  top bounds, inclusive
region_y1  in  NUM_REGIONS*CW  bottom bounds, inclusive
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active  out  1  pixel in visible area
pix_x  out  CW  current pixel column
pix_y  out  CW  current pixel line
pix_en  out  1  pixel-enable strobe
frame_start  out  1  one-cycle pulse at pixel (0,0)
cursor_x  out  CW  committed cursor X
cursor_y  out  CW  committed cursor Y
cursor_on  out  1  current pixel lies inside the cursor square
click_valid  out  1  one-cycle pulse: left click inside an enabled region
click_idx  out  4  index of the clicked region
click_miss  out  1  one-cycle pulse: left click outside every enabled region
hover_idx  out  4  lowest-index enabled region under the cursor
hover_valid  out  1  hover_idx is meaningful

Behaviour:
Reset (reset=0, asynchronous):
- All counters = 0; hsync = vsync = ~SYNC_POL.
- active, pix_en, frame_start, click_valid, click_miss, hover_valid = 0.
- click_idx = hover_idx = 0; pix_x = pix_y = 0.
- Committed and pending cursor = (H_ACTIVE/2, V_ACTIVE/2); previous-left-button register = 0.

Pixel-enable divider:
- Counts 0..CLK_DIV-1; pix_en high one in_clk cycle when the count is CLK_DIV-1.
- CLK_DIV=1 makes pix_en constant 1 after reset.

Timing counters (advance only on pix_en):
- h_cnt runs 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP.
- v_cnt increments when h_cnt wraps, and runs 0..V_TOT-1.
- Region order per line: active [0,H_ACTIVE), front porch, sync, back porch. Vertical uses the same order.
- Registered outputs, all updated together, one in_clk cycle after the pix_en that advances the counters:
  - pix_x/pix_y = h_cnt/v_cnt.
  - active = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - hsync = SYNC_POL while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise ~SYNC_POL. vsync is defined the same way.
  - frame_start = 1 for that one cycle when h_cnt=0 and v_cnt=0.

Cursor:
- On mv_valid, the pending position updates:
  - px' = clamp(px + sext(mv_dx), 0, H_ACTIVE-1)
  - py' = clamp(py - sext(mv_dy), 0, V_ACTIVE-1)
- Arithmetic is signed, CW+2 bits, so there is no wrap-around.
- Pending is copied to committed on the pix_en cycle where v_cnt becomes V_ACTIVE (start of vertical blank).
- If mv_valid coincides with the commit, the commit takes the old pending value; the new value waits for the next frame.
- cursor_on = active && cursor_x<=pix_x<=cursor_x+CUR_SIZE-1 && same test on y. Combinational from the registered outputs. Clipped at the screen edge naturally.

Hover:
- hover_valid/hover_idx are recomputed every cycle from the committed cursor.
- Priority: lowest index wins. A region matches if enabled and x0<=cx<=x1, y0<=cy<=y1 (inclusive).
- Registered, so there is 1 cycle of latency.

Click:
- On mv_valid with mv_btn[0]=1 and prev_left=0 (rising edge), one cycle later exactly one of these pulses:
  - click_valid with click_idx = the current hover result; or
  - click_miss.
- The hit test uses the committed cursor, not any motion in the same packet.
- prev_left updates on every mv_valid. A held button never repeats.
- Right and middle buttons are ignored.
- A region with x0>x1 or y0>y1 never matches.

Reset mid-frame: everything returns to the reset state immediately; the timing restarts at (0,0) after release, and no spurious pulses are produced.

Decomposition:
- Package vga_menu_pkg holds:
  - default 640x480@60 timing constants;
  - the H_TOT/V_TOT derivation;
  - function sext9(9b)->signed(CW+2);
  - function clamp(signed, lo, hi).
- Sub-module vga_timing_gen is the natural split: the divider, h/v counters, hsync/vsync/active/pix_x/pix_y/frame_start, and an exported vblank_start strobe.
- Cursor, hover and click logic stay in the top module.

Test Plan:
- Default params, CLK_DIV=4:
  - hsync low for exactly 384 in_clk cycles;
  - line period 3200 cycles;
  - vsync low for 2 lines;
  - frame = 525 lines;
  - frame_start period 1,680,000 cycles.
- From (320,240), mv_dx=+5, mv_dy=+3: cursor_x/cursor_y stay 320/240 until the next vblank, then read 325/237.
- From cursor_x=2, mv_dx=-5 (9'h1FB): cursor_x=0. Then mv_dx=+255 ×3: cursor_x=639.
- Region0 = (200..340, 220..260), region1 = (300..400, 200..300), both enabled; cursor (310,230):
  - left rising edge → click_valid with click_idx=0;
  - disable region0 → click_idx=1;
  - cursor (10,10) → click_miss.
- Four consecutive packets with mv_btn=3'b001 → exactly one click pulse. Packet with btn=0, then btn=1 → second pulse.
- Assert reset mid-line at pix (150,100) → outputs are at reset values within the same cycle; after release the first frame_start arrives 1 pixel-enable later, and there is no click pulse.
